// File: rtl/sdr_cpu_bridge_pkg.sv
// Shared types and widths for the 68000-to-SDRAM CPU bridge.
package sdr_cpu_bridge_pkg;

  localparam int SDR_AW = 26;
  localparam int CPU_AW = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bridge_state_t;

  // Reads always fetch the whole word so the read buffer can be filled.
  function automatic logic [1:0] req_be(input logic rw, input logic [1:0] ds_n);
    return rw ? 2'b11 : ~ds_n;
  endfunction

endpackage

// File: rtl/sdr_cpu_bridge_if.sv
// CPU-side bus plus SDRAM CPU-channel toggle port seen by the bridge.
interface sdr_cpu_bridge_if #(
  parameter int NREGIONS = 2
);
  import sdr_cpu_bridge_pkg::*;

  logic [CPU_AW-1:0]   cpu_addr;
  logic [1:0]          cpu_ds_n;
  logic                cpu_rw;
  logic [15:0]         cpu_dout;
  logic [NREGIONS-1:0] cs_n;
  logic [15:0]         cpu_din;
  logic                dtack_n;
  logic [SDR_AW-1:0]   sdr_cpu_addr;
  logic [15:0]         sdr_cpu_q;
  logic [15:0]         sdr_cpu_data;
  logic [1:0]          sdr_cpu_be;
  logic                sdr_cpu_rw;
  logic                sdr_cpu_req;
  logic                sdr_cpu_ack;

  modport master (
    output cpu_addr, cpu_ds_n, cpu_rw, cpu_dout, cs_n, sdr_cpu_q, sdr_cpu_ack,
    input  cpu_din, dtack_n, sdr_cpu_addr, sdr_cpu_data, sdr_cpu_be, sdr_cpu_rw, sdr_cpu_req
  );

  modport slave (
    input  cpu_addr, cpu_ds_n, cpu_rw, cpu_dout, cs_n, sdr_cpu_q, sdr_cpu_ack,
    output cpu_din, dtack_n, sdr_cpu_addr, sdr_cpu_data, sdr_cpu_be, sdr_cpu_rw, sdr_cpu_req
  );

endinterface

// File: rtl/sdr_cpu_bridge_rdbuf.sv
// Single-entry read buffer: tag/data filled by SDRAM reads, patched byte-wise by writes.
module sdr_cpu_rdbuf
  import sdr_cpu_bridge_pkg::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SDR_AW-1:0] lookup_addr,
  output logic              hit,
  output logic [15:0]       hit_data,
  input  logic [SDR_AW-1:0] upd_addr,
  input  logic              fill,
  input  logic [15:0]       fill_data,
  input  logic              wr,
  input  logic [1:0]        wr_be,
  input  logic [15:0]       wr_data
);

  logic              valid;
  logic [SDR_AW-1:0] tag;
  logic [15:0]       data;

  assign hit      = ENABLE && valid && (tag == lookup_addr);
  assign hit_data = data;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (ENABLE) begin
      if (fill) begin
        valid <= 1'b1;
        tag   <= upd_addr;
        data  <= fill_data;
      end else if (wr && valid && (tag == upd_addr)) begin
        if (wr_be[0]) data[7:0]  <= wr_data[7:0];
        if (wr_be[1]) data[15:8] <= wr_data[15:8];
      end
    end
  end

endmodule

// File: rtl/sdr_cpu_bridge.sv
// Maps active-low region selects onto SDRAM word addresses, runs the toggle req/ack
// handshake and generates DTACKn; read-only regions and a one-entry read buffer short-cut SDRAM.
module sdr_cpu_bridge
  import sdr_cpu_bridge_pkg::*;
#(
  parameter int                         NREGIONS    = 2,
  parameter logic [NREGIONS*SDR_AW-1:0] REGION_OFS  = {26'h100000, 26'h000000},
  parameter logic [NREGIONS*24-1:0]     REGION_MASK = {24'h0FFFFF, 24'h0FFFFF},
  parameter logic [NREGIONS-1:0]        RO_MASK     = 2'b01,
  parameter bit                         RDBUF       = 1'b1
) (
  input logic             clk,
  input logic             reset,
  sdr_cpu_bridge_if.slave bus
);

  bridge_state_t     state, state_nxt;
  logic              sel_vld, sel_ro;
  logic [SDR_AW-1:0] sel_ofs;
  logic [CPU_AW-1:0] sel_mask;
  logic [SDR_AW-1:0] start_addr;
  logic              access;
  logic              buf_hit;
  logic [15:0]       buf_data;
  logic              issue, hit_go, complete;

  logic              req_q;
  logic [SDR_AW-1:0] addr_q;
  logic [15:0]       data_q;
  logic [1:0]        be_q;
  logic              rw_q;
  logic [15:0]       din_q;

  // Lowest-numbered low select wins; the byte mask is applied to the word address.
  always_comb begin
    sel_vld  = 1'b0;
    sel_ro   = 1'b0;
    sel_ofs  = '0;
    sel_mask = '0;
    for (int i = 0; i < NREGIONS; i++) begin
      if (!sel_vld && !bus.cs_n[i]) begin
        sel_vld  = 1'b1;
        sel_ro   = RO_MASK[i];
        sel_ofs  = REGION_OFS[i*SDR_AW +: SDR_AW];
        sel_mask = REGION_MASK[i*24+1 +: CPU_AW];
      end
    end
  end

  assign start_addr = sel_ofs + SDR_AW'(bus.cpu_addr & sel_mask);
  assign access     = sel_vld && !(&bus.cpu_ds_n);

  sdr_cpu_rdbuf #(.ENABLE(RDBUF)) u_rdbuf (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (start_addr),
    .hit         (buf_hit),
    .hit_data    (buf_data),
    .upd_addr    (addr_q),
    .fill        (complete && rw_q),
    .fill_data   (bus.sdr_cpu_q),
    .wr          (complete && !rw_q),
    .wr_be       (be_q),
    .wr_data     (data_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    hit_go    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (bus.cpu_rw && buf_hit) begin
            state_nxt = DONE;
            hit_go    = 1'b1;
          end else if (!bus.cpu_rw && sel_ro) begin
            state_nxt = DONE;
          end else begin
            state_nxt = REQ;
            issue     = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus.sdr_cpu_ack == req_q) begin
          state_nxt = DONE;
          complete  = 1'b1;
        end
      end
      DONE: begin
        if (&bus.cpu_ds_n) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // On reset req is re-aligned to ack so an abandoned request is not left pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q  <= bus.sdr_cpu_ack;
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
      rw_q   <= 1'b0;
      din_q  <= '0;
    end else begin
      if (issue) begin
        req_q  <= ~req_q;
        addr_q <= start_addr;
        data_q <= bus.cpu_dout;
        be_q   <= req_be(bus.cpu_rw, bus.cpu_ds_n);
        rw_q   <= bus.cpu_rw;
      end
      if (hit_go)            din_q <= buf_data;
      if (complete && rw_q)  din_q <= bus.sdr_cpu_q;
    end
  end

  assign bus.cpu_din      = din_q;
  assign bus.dtack_n      = (state != DONE);
  assign bus.sdr_cpu_addr = addr_q;
  assign bus.sdr_cpu_data = data_q;
  assign bus.sdr_cpu_be   = be_q;
  assign bus.sdr_cpu_rw   = rw_q;
  assign bus.sdr_cpu_req  = req_q;

endmodule

// File: tb/tb_sdr_cpu_bridge.sv
// Directed bench for sdr_cpu_bridge: miss, buffer hit, write-through, read-only drop, reset abort.
module tb_sdr_cpu_bridge;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  sdr_cpu_bridge_if #(.NREGIONS(2)) bus ();

  sdr_cpu_bridge #(.NREGIONS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_start(input logic [1:0] cs, input logic [22:0] waddr,
                           input logic rw, input logic [1:0] ds, input logic [15:0] dout);
    bus.cs_n     = cs;
    bus.cpu_addr = waddr;
    bus.cpu_rw   = rw;
    bus.cpu_ds_n = ds;
    bus.cpu_dout = dout;
  endtask

  task automatic cpu_release();
    bus.cpu_ds_n = 2'b11;
    bus.cs_n     = 2'b11;
  endtask

  initial begin
    reset        = 1'b1;
    bus.cs_n     = 2'b11;
    bus.cpu_ds_n = 2'b11;
    bus.cpu_rw   = 1'b1;
    bus.cpu_addr = '0;
    bus.cpu_dout = '0;
    bus.sdr_cpu_q   = '0;
    bus.sdr_cpu_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    check("rst_dtack", 32'(bus.dtack_n), 32'h1);
    check("rst_din",   32'(bus.cpu_din), 32'h0);
    check("rst_req",   32'(bus.sdr_cpu_req), 32'h0);
    check("rst_addr",  32'(bus.sdr_cpu_addr), 32'h0);
    check("rst_be",    32'(bus.sdr_cpu_be), 32'h0);
    check("rst_rw",    32'(bus.sdr_cpu_rw), 32'h0);
    check("rst_data",  32'(bus.sdr_cpu_data), 32'h0);

    // DS low with no select: nothing happens.
    cpu_start(2'b11, 23'h080020, 1'b1, 2'b00, 16'h0);
    tick(2);
    check("nocs_dtack", 32'(bus.dtack_n), 32'h1);
    check("nocs_req",   32'(bus.sdr_cpu_req), 32'h0);
    cpu_release();
    tick(1);

    // Read miss, region 1, cpu byte 0x100040 (word 0x080020) -> SDRAM word 0x100020.
    cpu_start(2'b01, 23'h080020, 1'b1, 2'b00, 16'h0);
    tick(1);
    check("rd_req",   32'(bus.sdr_cpu_req), 32'h1);
    check("rd_addr",  32'(bus.sdr_cpu_addr), 32'h100020);
    check("rd_rw",    32'(bus.sdr_cpu_rw), 32'h1);
    check("rd_be",    32'(bus.sdr_cpu_be), 32'h3);
    check("rd_dtack", 32'(bus.dtack_n), 32'h1);
    bus.cs_n = 2'b10;
    tick(6);
    check("rd_wait_dtack", 32'(bus.dtack_n), 32'h1);
    check("rd_wait_req",   32'(bus.sdr_cpu_req), 32'h1);
    check("rd_cs_ignored", 32'(bus.sdr_cpu_addr), 32'h100020);
    bus.sdr_cpu_q   = 16'hBEEF;
    bus.sdr_cpu_ack = 1'b1;
    tick(1);
    check("rd_done_dtack", 32'(bus.dtack_n), 32'h0);
    check("rd_done_din",   32'(bus.cpu_din), 32'hBEEF);
    bus.sdr_cpu_q = 16'h0000;
    tick(1);
    check("rd_hold_dtack", 32'(bus.dtack_n), 32'h0);
    check("rd_hold_din",   32'(bus.cpu_din), 32'hBEEF);
    cpu_release();
    tick(1);
    check("rd_end_dtack", 32'(bus.dtack_n), 32'h1);

    // Same read again: buffer hit, no SDRAM request.
    cpu_start(2'b01, 23'h080020, 1'b1, 2'b00, 16'h0);
    tick(1);
    check("hit_dtack", 32'(bus.dtack_n), 32'h0);
    check("hit_din",   32'(bus.cpu_din), 32'hBEEF);
    check("hit_req",   32'(bus.sdr_cpu_req), 32'h1);
    cpu_release();
    tick(1);
    check("hit_end_dtack", 32'(bus.dtack_n), 32'h1);

    // LDS-only write to the buffered address: goes to SDRAM and patches the buffer.
    cpu_start(2'b01, 23'h080020, 1'b0, 2'b10, 16'h00AA);
    tick(1);
    check("wr_req",   32'(bus.sdr_cpu_req), 32'h0);
    check("wr_be",    32'(bus.sdr_cpu_be), 32'h1);
    check("wr_rw",    32'(bus.sdr_cpu_rw), 32'h0);
    check("wr_data",  32'(bus.sdr_cpu_data), 32'h00AA);
    check("wr_addr",  32'(bus.sdr_cpu_addr), 32'h100020);
    tick(2);
    check("wr_wait_dtack", 32'(bus.dtack_n), 32'h1);
    bus.sdr_cpu_ack = 1'b0;
    tick(1);
    check("wr_done_dtack", 32'(bus.dtack_n), 32'h0);
    cpu_release();
    tick(1);
    check("wr_end_dtack", 32'(bus.dtack_n), 32'h1);

    bus.sdr_cpu_q = 16'h1234;
    cpu_start(2'b01, 23'h080020, 1'b1, 2'b00, 16'h0);
    tick(1);
    check("wt_hit_dtack", 32'(bus.dtack_n), 32'h0);
    check("wt_hit_din",   32'(bus.cpu_din), 32'hBEAA);
    check("wt_hit_req",   32'(bus.sdr_cpu_req), 32'h0);
    cpu_release();
    tick(1);

    // Write to read-only region 0: acknowledged without an SDRAM request.
    cpu_start(2'b10, 23'h000010, 1'b0, 2'b00, 16'h5555);
    tick(1);
    check("ro_dtack", 32'(bus.dtack_n), 32'h0);
    check("ro_req",   32'(bus.sdr_cpu_req), 32'h0);
    check("ro_addr",  32'(bus.sdr_cpu_addr), 32'h100020);
    cpu_release();
    tick(1);
    check("ro_end_dtack", 32'(bus.dtack_n), 32'h1);
    cpu_start(2'b01, 23'h080020, 1'b1, 2'b00, 16'h0);
    tick(1);
    check("ro_buf_din", 32'(bus.cpu_din), 32'hBEAA);
    check("ro_buf_req", 32'(bus.sdr_cpu_req), 32'h0);
    cpu_release();
    tick(1);

    // Reset while a read miss is outstanding.
    cpu_start(2'b01, 23'h080040, 1'b1, 2'b00, 16'h0);
    tick(1);
    check("ab_req",  32'(bus.sdr_cpu_req), 32'h1);
    check("ab_addr", 32'(bus.sdr_cpu_addr), 32'h100040);
    reset = 1'b1;
    tick(1);
    check("ab_dtack", 32'(bus.dtack_n), 32'h1);
    check("ab_req_aligned", 32'(bus.sdr_cpu_req), 32'(bus.sdr_cpu_ack));
    check("ab_req_val", 32'(bus.sdr_cpu_req), 32'h0);
    check("ab_din",   32'(bus.cpu_din), 32'h0);
    cpu_release();
    reset = 1'b0;
    tick(1);

    // Previously buffered address must now miss.
    cpu_start(2'b01, 23'h080020, 1'b1, 2'b00, 16'h0);
    tick(1);
    check("post_rst_req",   32'(bus.sdr_cpu_req), 32'h1);
    check("post_rst_dtack", 32'(bus.dtack_n), 32'h1);
    bus.sdr_cpu_q   = 16'hC0DE;
    bus.sdr_cpu_ack = 1'b1;
    tick(1);
    check("post_rst_done", 32'(bus.dtack_n), 32'h0);
    check("post_rst_din",  32'(bus.cpu_din), 32'hC0DE);
    cpu_release();
    tick(1);
    check("post_rst_end", 32'(bus.dtack_n), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
